ring_port_controller: RTL and testbench

- Client-side controller for one ring stop on the circular memory ring. It drives the stop's overwrite, addr/data/id/packet_type request inputs, and consumes the stop's request-side outputs.
- Buffers client requests in a small FIFO and injects them into empty ring slots.
- Removes responses addressed to this port from the ring, frees the slot, and presents them to the client on a valid/ready interface.

---
 rtl/ring_pkg.sv | 25 ++
 rtl/ring_req_fifo.sv | 72 +++++++
 rtl/ring_port_controller.sv | 158 +++++++++++++++
 tb/tb_ring_port_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared ring packet definitions for the ring stop client controllers.
// The request entry struct is declared in the controller because its data width follows DEPTH.
package ring_pkg;

  localparam int ADDR_W = 36;
  localparam int ID_W   = 5;
  localparam int PT_W   = 3;

  typedef enum logic [PT_W-1:0] {
    PT_EMPTY     = 3'd0,
    PT_READ_REQ  = 3'd1,
    PT_WRITE_REQ = 3'd2,
    PT_READ_RESP = 3'd3,
    PT_WRITE_ACK = 3'd4
  } pkt_type_e;

  function automatic logic is_request(input logic [PT_W-1:0] ptype);
    return (ptype == PT_READ_REQ) || (ptype == PT_WRITE_REQ);
  endfunction

  function automatic logic is_response(input logic [PT_W-1:0] ptype);
    return (ptype == PT_READ_RESP) || (ptype == PT_WRITE_ACK);
  endfunction

endpackage

// File: rtl/ring_req_fifo.sv
// Request FIFO for the ring port: async active-low reset, head visible combinationally.
// Pushes while full and pops while empty are ignored.
module ring_req_fifo #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    head    = mem_q[rd_ptr_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Entries are a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ring_port_controller.sv
// Client-side controller for one ring stop: queues client requests, injects them into empty
// slots, and removes responses addressed to MY_ID into a valid/ready response register.
module ring_port_controller
  import ring_pkg::*;
#(
  parameter int              DEPTH           = 512,
  parameter int              FIFO_DEPTH      = 4,
  parameter logic [ID_W-1:0] MY_ID           = '0,
  parameter int              MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DEPTH-1:0]  req_data,
  input  logic [PT_W-1:0]   req_type,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DEPTH-1:0]  resp_data,
  output logic [PT_W-1:0]   resp_type,

  input  logic [ADDR_W-1:0] ring_addr_in,
  input  logic [DEPTH-1:0]  ring_data_in,
  input  logic [ID_W-1:0]   ring_id_in,
  input  logic [PT_W-1:0]   ring_type_in,

  output logic              overwrite,
  output logic [ADDR_W-1:0] ring_addr_out,
  output logic [DEPTH-1:0]  ring_data_out,
  output logic [ID_W-1:0]   ring_id_out,
  output logic [PT_W-1:0]   ring_type_out
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DEPTH-1:0]  data;
    logic [PT_W-1:0]   ptype;
  } ring_req_t;

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  ring_req_t         push_entry;
  ring_req_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;

  logic              mine;
  logic              cap_ok;
  logic              can_inj;
  logic              capture;
  logic              inject;
  logic              settle_one;

  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              resp_valid_q,  resp_valid_d;
  logic [ADDR_W-1:0] resp_addr_q,   resp_addr_d;
  logic [DEPTH-1:0]  resp_data_q,   resp_data_d;
  logic [PT_W-1:0]   resp_type_q,   resp_type_d;

  // Illegal request types are acknowledged but never reach the FIFO.
  always_comb begin
    req_ready       = !fifo_full;
    fifo_push       = req_valid && !fifo_full && is_request(req_type);
    push_entry      = '0;
    push_entry.addr = req_addr;
    push_entry.data = req_data;
    push_entry.ptype = req_type;
  end

  ring_req_fifo #(
    .WIDTH   ($bits(ring_req_t)),
    .ENTRIES (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (inject),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A slot freed by a capture is reused for injection in the same cycle when possible.
  always_comb begin
    mine       = is_response(ring_type_in) && (ring_id_in == MY_ID);
    cap_ok     = !resp_valid_q || resp_ready;
    can_inj    = !fifo_empty && (outstanding_q < OUT_MAX);
    capture    = rst && mine && cap_ok;
    inject     = rst && can_inj && (capture || (ring_type_in == PT_EMPTY));
    settle_one = capture && (outstanding_q != '0);
  end

  always_comb begin
    overwrite     = capture || inject;
    ring_addr_out = '0;
    ring_data_out = '0;
    ring_id_out   = '0;
    ring_type_out = PT_EMPTY;
    if (inject) begin
      ring_addr_out = fifo_head.addr;
      ring_data_out = fifo_head.data;
      ring_id_out   = MY_ID;
      ring_type_out = fifo_head.ptype;
    end
  end

  // A stray response (nothing outstanding) is still captured but leaves the count at zero.
  always_comb begin
    case ({inject, settle_one})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    resp_valid_d = capture || (resp_valid_q && !resp_ready);
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    resp_type_d  = resp_type_q;
    if (capture) begin
      resp_addr_d = ring_addr_in;
      resp_data_d = ring_data_in;
      resp_type_d = ring_type_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_addr_q   <= '0;
      resp_data_q   <= '0;
      resp_type_q   <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      resp_valid_q  <= resp_valid_d;
      resp_addr_q   <= resp_addr_d;
      resp_data_q   <= resp_data_d;
      resp_type_q   <= resp_type_d;
    end
  end

  always_comb begin
    resp_valid = resp_valid_q;
    resp_addr  = resp_addr_q;
    resp_data  = resp_data_q;
    resp_type  = resp_type_q;
  end

endmodule

// File: tb/tb_ring_port_controller.sv
// Directed bench for ring_port_controller: a queue-based model is compared every cycle,
// and literal expectations pin key cycles of each scenario.
module tb_ring_port_controller;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [35:0]   req_addr;
  logic [DW-1:0] req_data;
  logic [2:0]    req_type;
  logic          resp_valid;
  logic          resp_ready;
  logic [35:0]   resp_addr;
  logic [DW-1:0] resp_data;
  logic [2:0]    resp_type;
  logic [35:0]   ring_addr_in;
  logic [DW-1:0] ring_data_in;
  logic [4:0]    ring_id_in;
  logic [2:0]    ring_type_in;
  logic          overwrite;
  logic [35:0]   ring_addr_out;
  logic [DW-1:0] ring_data_out;
  logic [4:0]    ring_id_out;
  logic [2:0]    ring_type_out;

  int total = 0;
  int bad   = 0;

  ring_port_controller #(
    .DEPTH           (DW),
    .FIFO_DEPTH      (4),
    .MY_ID           (5'd0),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_type      (req_type),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_addr     (resp_addr),
    .resp_data     (resp_data),
    .resp_type     (resp_type),
    .ring_addr_in  (ring_addr_in),
    .ring_data_in  (ring_data_in),
    .ring_id_in    (ring_id_in),
    .ring_type_in  (ring_type_in),
    .overwrite     (overwrite),
    .ring_addr_out (ring_addr_out),
    .ring_data_out (ring_data_out),
    .ring_id_out   (ring_id_out),
    .ring_type_out (ring_type_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0]   addr;
    logic [DW-1:0] data;
    logic [2:0]    ptype;
  } req_t;

  req_t          m_fifo[$];
  int            m_out = 0;
  bit            m_rv = 1'b0;
  logic [35:0]   m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [2:0]    m_type = '0;
  bit            m_mine, m_cap, m_inj;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Decide what the port must do with the slot currently in front of it.
  function automatic void modelDecide();
    m_mine = (ring_type_in == 3'd3 || ring_type_in == 3'd4) && (ring_id_in == 5'd0);
    m_cap  = (rst === 1'b1) && m_mine && (!m_rv || resp_ready);
    m_inj  = (rst === 1'b1) && (m_fifo.size() > 0) && (m_out < 2) &&
             (m_cap || ring_type_in == 3'd0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete();
      m_out  = 0;
      m_rv   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_type = '0;
    end else begin
      bit   take;
      req_t r;
      modelDecide();
      take = req_valid && (m_fifo.size() < 4) && (req_type == 3'd1 || req_type == 3'd2);
      r.addr  = req_addr;
      r.data  = req_data;
      r.ptype = req_type;
      if (m_inj) void'(m_fifo.pop_front());
      m_out = m_out + (m_inj ? 1 : 0) - ((m_cap && m_out > 0) ? 1 : 0);
      if (m_cap) begin
        m_rv   = 1'b1;
        m_addr = ring_addr_in;
        m_data = ring_data_in;
        m_type = ring_type_in;
      end else if (resp_ready) begin
        m_rv = 1'b0;
      end
      if (take) m_fifo.push_back(r);
    end
  end

  always @(negedge clk) begin
    modelDecide();
    checkOutput("overwrite", overwrite, (m_cap || m_inj));
    if (m_inj) begin
      checkOutput("ring_type_out", ring_type_out, m_fifo[0].ptype);
      checkOutput("ring_addr_out", ring_addr_out, m_fifo[0].addr);
      checkOutput("ring_data_out", ring_data_out, m_fifo[0].data);
      checkOutput("ring_id_out", ring_id_out, 5'd0);
    end else begin
      checkOutput("ring_type_out_empty", ring_type_out, 3'd0);
      checkOutput("ring_addr_out_zero", ring_addr_out, '0);
      checkOutput("ring_id_out_zero", ring_id_out, 5'd0);
    end
    checkOutput("req_ready", req_ready, (m_fifo.size() < 4));
    checkOutput("resp_valid", resp_valid, m_rv);
    if (m_rv) begin
      checkOutput("resp_addr", resp_addr, m_addr);
      checkOutput("resp_type", resp_type, m_type);
      if (m_type == 3'd3) checkOutput("resp_data", resp_data, m_data);
    end else if (!rst) begin
      checkOutput("resp_addr_reset", resp_addr, '0);
      checkOutput("resp_data_reset", resp_data, '0);
    end
  end

  task automatic applyStimulus(input logic [2:0] t, input logic [4:0] id,
                               input logic [35:0] a, input logic [DW-1:0] d);
    ring_type_in = t;
    ring_id_in   = id;
    ring_addr_in = a;
    ring_data_in = d;
  endtask

  task automatic setReq(input logic v, input logic [2:0] t, input logic [35:0] a,
                        input logic [DW-1:0] d);
    req_valid = v;
    req_type  = t;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    resp_ready = 1'b1;
    setReq(1'b0, 3'd0, '0, '0);
    applyStimulus(3'd0, 5'd0, '0, '0);
    settle();
    checkOutput("lit_reset_overwrite", overwrite, 1'b0);
    checkOutput("lit_reset_resp_valid", resp_valid, 1'b0);
    checkOutput("lit_reset_req_ready", req_ready, 1'b1);
    nextCycle();
    rst = 1'b1;

    // Read flow
    setReq(1'b1, 3'd1, 36'h0_0000_0040, '0);
    settle();
    checkOutput("lit_no_bypass", overwrite, 1'b0);
    nextCycle();
    setReq(1'b0, 3'd0, '0, '0);
    settle();
    checkOutput("lit_rd_inject_ow", overwrite, 1'b1);
    checkOutput("lit_rd_inject_type", ring_type_out, 3'd1);
    checkOutput("lit_rd_inject_id", ring_id_out, 5'd0);
    checkOutput("lit_rd_inject_addr", ring_addr_out, 36'h40);
    nextCycle();
    applyStimulus(3'd3, 5'd0, 36'h40, {64{8'hA5}});
    settle();
    checkOutput("lit_rd_capture_ow", overwrite, 1'b1);
    checkOutput("lit_rd_capture_type", ring_type_out, 3'd0);
    nextCycle();
    applyStimulus(3'd0, 5'd0, '0, '0);
    settle();
    checkOutput("lit_rd_resp_valid", resp_valid, 1'b1);
    checkOutput("lit_rd_resp_data", resp_data, {64{8'hA5}});
    checkOutput("lit_rd_resp_type", resp_type, 3'd3);

    // Backpressure
    nextCycle();
    resp_ready = 1'b0;
    applyStimulus(3'd4, 5'd0, 36'h200, '0);
    settle();
    checkOutput("lit_bp_first_capture", overwrite, 1'b1);
    nextCycle();
    applyStimulus(3'd3, 5'd0, 36'h300, {64{8'h5A}});
    settle();
    checkOutput("lit_bp_pass_ow", overwrite, 1'b0);
    checkOutput("lit_bp_held_addr", resp_addr, 36'h200);
    checkOutput("lit_bp_held_type", resp_type, 3'd4);
    nextCycle();
    settle();
    checkOutput("lit_bp_stable_addr", resp_addr, 36'h200);
    nextCycle();
    resp_ready = 1'b1;
    applyStimulus(3'd0, 5'd0, '0, '0);
    settle();
    nextCycle();
    settle();
    checkOutput("lit_bp_cleared", resp_valid, 1'b0);

    // Foreign traffic with a queued write
    nextCycle();
    setReq(1'b1, 3'd2, 36'h100, {64{8'h11}});
    applyStimulus(3'd3, 5'd3, 36'h500, {64{8'h77}});
    settle();
    checkOutput("lit_foreign_resp_ow", overwrite, 1'b0);
    nextCycle();
    setReq(1'b0, 3'd0, '0, '0);
    settle();
    checkOutput("lit_foreign_resp_ow2", overwrite, 1'b0);
    nextCycle();
    applyStimulus(3'd2, 5'd5, 36'h600, {64{8'h66}});
    settle();
    checkOutput("lit_foreign_req_ow", overwrite, 1'b0);

    // Slot reuse: capture and inject in the same slot
    nextCycle();
    applyStimulus(3'd4, 5'd0, 36'h80, '0);
    settle();
    checkOutput("lit_reuse_ow", overwrite, 1'b1);
    checkOutput("lit_reuse_type", ring_type_out, 3'd2);
    checkOutput("lit_reuse_addr", ring_addr_out, 36'h100);
    checkOutput("lit_reuse_data", ring_data_out, {64{8'h11}});
    nextCycle();
    applyStimulus(3'd0, 5'd0, '0, '0);
    settle();
    checkOutput("lit_reuse_resp_addr", resp_addr, 36'h80);
    nextCycle();
    applyStimulus(3'd4, 5'd0, 36'h90, '0);
    settle();

    // Outstanding limit of two
    nextCycle();
    applyStimulus(3'd0, 5'd0, '0, '0);
    setReq(1'b1, 3'd1, 36'hA00, '0);
    settle();
    nextCycle();
    setReq(1'b1, 3'd1, 36'hA10, '0);
    settle();
    checkOutput("lit_lim_inj1_addr", ring_addr_out, 36'hA00);
    nextCycle();
    setReq(1'b1, 3'd2, 36'hA20, {64{8'h22}});
    settle();
    checkOutput("lit_lim_inj2_addr", ring_addr_out, 36'hA10);
    nextCycle();
    setReq(1'b0, 3'd0, '0, '0);
    settle();
    checkOutput("lit_lim_blocked", overwrite, 1'b0);
    nextCycle();
    settle();
    checkOutput("lit_lim_blocked2", overwrite, 1'b0);
    nextCycle();
    applyStimulus(3'd3, 5'd0, 36'hA00, {64{8'h44}});
    settle();
    checkOutput("lit_lim_capture_ow", overwrite, 1'b1);
    checkOutput("lit_lim_capture_type", ring_type_out, 3'd0);
    nextCycle();
    applyStimulus(3'd0, 5'd0, '0, '0);
    settle();
    checkOutput("lit_lim_release_type", ring_type_out, 3'd2);
    checkOutput("lit_lim_release_addr", ring_addr_out, 36'hA20);

    // Fill the FIFO with no empty slots on the ring
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(3'd2, 5'd7, 36'h700, '0);
      setReq(1'b1, 3'd1, 36'hB00 + 36'(i), '0);
      settle();
      if (i < 4) checkOutput("lit_fill_ready", req_ready, 1'b1);
      else       checkOutput("lit_fill_full", req_ready, 1'b0);
    end

    // Hold a response, then reset mid-operation
    nextCycle();
    setReq(1'b0, 3'd0, '0, '0);
    resp_ready = 1'b0;
    applyStimulus(3'd4, 5'd0, 36'hC00, '0);
    settle();
    nextCycle();
    applyStimulus(3'd2, 5'd7, 36'h700, '0);
    settle();
    checkOutput("lit_held_before_reset", resp_valid, 1'b1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(3'd0, 5'd0, '0, '0);
    #1;
    checkOutput("lit_rst_ow", overwrite, 1'b0);
    checkOutput("lit_rst_resp_valid", resp_valid, 1'b0);
    checkOutput("lit_rst_req_ready", req_ready, 1'b1);
    settle();
    nextCycle();
    rst = 1'b1;
    resp_ready = 1'b1;
    settle();
    checkOutput("lit_post_rst_idle", overwrite, 1'b0);
    nextCycle();
    setReq(1'b1, 3'd5, 36'hD00, '0);
    settle();
    nextCycle();
    setReq(1'b0, 3'd0, '0, '0);
    settle();
    checkOutput("lit_illegal_discarded", overwrite, 1'b0);
    nextCycle();
    applyStimulus(3'd3, 5'd0, 36'hE00, {64{8'h3C}});
    settle();
    checkOutput("lit_stray_capture", overwrite, 1'b1);
    nextCycle();
    applyStimulus(3'd0, 5'd0, '0, '0);
    setReq(1'b1, 3'd1, 36'hF00, '0);
    settle();
    checkOutput("lit_stray_resp_data", resp_data, {64{8'h3C}});
    nextCycle();
    setReq(1'b0, 3'd0, '0, '0);
    settle();
    checkOutput("lit_new_inject_type", ring_type_out, 3'd1);
    checkOutput("lit_new_inject_addr", ring_addr_out, 36'hF00);
    nextCycle();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
